hack_rom_loader: RTL

- Streams a program image from the AVR serial byte receiver into the HACK instruction ROM.
- Drives the ROM write port: ROMDataLine, ROMAddressLineCtl, ROMLoad.
- Holds the HACK CPU in reset while a load is in progress.
- Sits in mojo_top between the UART byte receiver and the HACK instance, and replaces the external ROM-load pins.

---
 rtl/hack_pkg.sv | 25 ++
 rtl/byte_timeout.sv | 32 +++
 rtl/hack_rom_loader.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/hack_pkg.sv
// Shared types and constants for the HACK program-image loader.
package hack_pkg;

  localparam int HACK_WORD_W     = 16;
  localparam int DEF_ADDR_W      = 15;
  localparam int DEF_TIMEOUT_CYC = 5_000_000;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_D_HI   = 3'd3,
    ST_D_LO   = 3'd4,
    ST_CHK    = 3'd5,
    ST_FAIL   = 3'd6
  } load_state_e;

  // Frame checksum accumulates data bytes modulo 256.
  function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] data);
    return sum + data;
  endfunction

endpackage

// File: rtl/byte_timeout.sv
// Counts idle clk cycles between received bytes; expire marks a stalled frame.
module byte_timeout
  import hack_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_r;

  // Gap counter; holds at LAST_CNT until the next clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && (cnt_r != LAST_CNT)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign expire = (cnt_r == LAST_CNT);

endmodule

// File: rtl/hack_rom_loader.sv
// Streams a framed program image from the serial byte receiver into the HACK
// instruction ROM, holding the CPU in reset until a frame checks out.
module hack_rom_loader
  import hack_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [ADDR_W-1:0]      rom_addr,
  output logic [HACK_WORD_W-1:0] rom_data,
  output logic                   rom_load,
  output logic                   cpu_rst,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  load_state_e state_r, next_state_s;

  logic [7:0]             len_hi_r, hi_r, chk_r;
  logic [CNT_W-1:0]       words_r;
  logic [ADDR_W-1:0]      addr_r;
  logic [HACK_WORD_W-1:0] data_r;
  logic                   load_r, cpu_rst_r, busy_r, done_r, error_r;

  logic [16:0] len_s;
  logic        len_bad_s, sync_s, expire_s, to_clr_s;

  assign len_s     = {1'b0, len_hi_r, rx_data};
  assign len_bad_s = (len_s == 17'd0) || (len_s > MAX_WORDS);
  assign sync_s    = rx_valid && (rx_data == SYNC_BYTE);
  assign to_clr_s  = rx_valid || !busy_r;

  byte_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (to_clr_s),
    .en     (busy_r),
    .expire (expire_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; a received byte takes precedence over a timeout.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sync_s) next_state_s = ST_LEN_HI;
        else        next_state_s = ST_IDLE;
      end
      ST_LEN_HI: begin
        if (rx_valid)      next_state_s = ST_LEN_LO;
        else if (expire_s) next_state_s = ST_FAIL;
        else               next_state_s = ST_LEN_HI;
      end
      ST_LEN_LO: begin
        if (rx_valid)      next_state_s = len_bad_s ? ST_FAIL : ST_D_HI;
        else if (expire_s) next_state_s = ST_FAIL;
        else               next_state_s = ST_LEN_LO;
      end
      ST_D_HI: begin
        if (rx_valid)      next_state_s = ST_D_LO;
        else if (expire_s) next_state_s = ST_FAIL;
        else               next_state_s = ST_D_HI;
      end
      ST_D_LO: begin
        if (rx_valid)      next_state_s = (words_r == CNT_W'(1)) ? ST_CHK : ST_D_HI;
        else if (expire_s) next_state_s = ST_FAIL;
        else               next_state_s = ST_D_LO;
      end
      ST_CHK: begin
        if (rx_valid)      next_state_s = (rx_data == chk_r) ? ST_IDLE : ST_FAIL;
        else if (expire_s) next_state_s = ST_FAIL;
        else               next_state_s = ST_CHK;
      end
      ST_FAIL: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Frame datapath, ROM write port and sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi_r  <= 8'd0;
      hi_r      <= 8'd0;
      chk_r     <= 8'd0;
      words_r   <= '0;
      addr_r    <= '0;
      data_r    <= '0;
      load_r    <= 1'b0;
      cpu_rst_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      load_r <= (state_r == ST_D_LO) && rx_valid;
      // words_r is already decremented here, so zero means the last word went out.
      if (load_r) begin
        addr_r <= (words_r == '0) ? '0 : addr_r + ADDR_W'(1);
      end
      case (state_r)
        ST_IDLE: begin
          if (sync_s) begin
            busy_r    <= 1'b1;
            cpu_rst_r <= 1'b1;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
          end
        end
        ST_LEN_HI: begin
          if (rx_valid) len_hi_r <= rx_data;
        end
        ST_LEN_LO: begin
          if (rx_valid && !len_bad_s) begin
            words_r <= len_s[CNT_W-1:0];
            addr_r  <= '0;
            chk_r   <= 8'd0;
          end
        end
        ST_D_HI: begin
          if (rx_valid) begin
            hi_r  <= rx_data;
            chk_r <= chk_add(chk_r, rx_data);
          end
        end
        ST_D_LO: begin
          if (rx_valid) begin
            data_r  <= {hi_r, rx_data};
            chk_r   <= chk_add(chk_r, rx_data);
            words_r <= words_r - CNT_W'(1);
          end
        end
        ST_CHK: begin
          if (rx_valid && (rx_data == chk_r)) begin
            busy_r    <= 1'b0;
            cpu_rst_r <= 1'b0;
            done_r    <= 1'b1;
          end
        end
        ST_FAIL: begin
          error_r <= 1'b1;
          busy_r  <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr = addr_r;
  assign rom_data = data_r;
  assign rom_load = load_r & ~rst;
  assign cpu_rst  = cpu_rst_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign error    = error_r;

endmodule
